// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: requester ids, read-return tags and the
// conflict counter ceiling.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        PORT_BIOS = 2'd0,
        PORT_D    = 2'd1,
        PORT_I    = 2'd2
    } ram_port_id_t;

    typedef struct packed {
        logic         valid;
        ram_port_id_t id;
    } ram_arb_tag_t;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

endpackage

// File: rtl/ram_arb_tag_pipe.sv
// Fixed-depth shift register of read tags; an entry leaving the last stage
// lines up with the RAM read data it describes.
module ram_arb_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  ram_arb_tag_t tag_in,
    output ram_arb_tag_t tag_out
);

    ram_arb_tag_t [DEPTH-1:0] tag_q;
    ram_arb_tag_t [DEPTH-1:0] tag_d;

    always_comb begin
        tag_d[0] = tag_in;
        for (int s = 1; s < DEPTH; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: BIOS owns RAM before boot, CPU data/instruction
// ports share it round-robin afterwards; read data is steered back by tag.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    booted,

    input  logic                    bios_req,
    input  logic                    bios_we,
    input  logic [DATA_WIDTH/8-1:0] bios_be,
    input  logic [ADDR_WIDTH-1:0]   bios_addr,
    input  logic [DATA_WIDTH-1:0]   bios_wdata,
    output logic                    bios_gnt,
    output logic                    bios_rvalid,
    output logic [DATA_WIDTH-1:0]   bios_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    input  logic                    i_req,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    output logic                    ram_en,
    output logic                    ram_we,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata,

    output logic [15:0]             conflict_cnt
);

    // last_i_q = 1 means the instruction port was granted most recently.
    logic         last_i_q, last_i_d;
    logic [15:0]  cnt_q, cnt_d;
    ram_arb_tag_t tag_in, tag_out;

    // Grants are forced low during reset so nothing reaches the RAM.
    assign bios_gnt = rst_n & ~booted & bios_req;
    assign d_gnt    = rst_n & booted & d_req & (~i_req | last_i_q);
    assign i_gnt    = rst_n & booted & i_req & (~d_req | ~last_i_q);
    assign ram_en   = bios_gnt | d_gnt | i_gnt;

    always_comb begin
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        tag_in    = '{valid: 1'b0, id: PORT_BIOS};
        if (bios_gnt) begin
            ram_we    = bios_we;
            ram_be    = bios_be;
            ram_addr  = bios_addr;
            ram_wdata = bios_wdata;
            tag_in.id = PORT_BIOS;
        end else if (d_gnt) begin
            ram_we    = d_we;
            ram_be    = d_be;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
            tag_in.id = PORT_D;
        end else if (i_gnt) begin
            ram_we    = i_we;
            ram_be    = i_be;
            ram_addr  = i_addr;
            ram_wdata = i_wdata;
            tag_in.id = PORT_I;
        end
        tag_in.valid = ram_en & ~ram_we;
    end

    always_comb begin
        last_i_d = last_i_q;
        if (d_gnt) begin
            last_i_d = 1'b0;
        end else if (i_gnt) begin
            last_i_d = 1'b1;
        end
        cnt_d = cnt_q;
        if (booted && d_req && i_req && cnt_q != CONFLICT_MAX) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_i_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            last_i_q <= last_i_d;
            cnt_q    <= cnt_d;
        end
    end

    ram_arb_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bios_rvalid  = tag_out.valid && (tag_out.id == PORT_BIOS);
    assign d_rvalid     = tag_out.valid && (tag_out.id == PORT_D);
    assign i_rvalid     = tag_out.valid && (tag_out.id == PORT_I);
    assign bios_rdata   = ram_rdata;
    assign d_rdata      = ram_rdata;
    assign i_rdata      = ram_rdata;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, per-cycle reference model of grants,
// read returns and conflict count, plus directed scenarios.
module tb_ram_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n, booted;
    logic        bios_req, bios_we, d_req, d_we, i_req, i_we;
    logic [3:0]  bios_be, d_be, i_be;
    logic [31:0] bios_addr, bios_wdata, d_addr, d_wdata, i_addr, i_wdata;
    logic        bios_gnt, bios_rvalid, d_gnt, d_rvalid, i_gnt, i_rvalid;
    logic [31:0] bios_rdata, d_rdata, i_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [15:0] conflict_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .booted(booted),
        .bios_req(bios_req), .bios_we(bios_we), .bios_be(bios_be),
        .bios_addr(bios_addr), .bios_wdata(bios_wdata), .bios_gnt(bios_gnt),
        .bios_rvalid(bios_rvalid), .bios_rdata(bios_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .i_req(i_req), .i_we(i_we), .i_be(i_be), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
    );

    // Read-first RAM with LAT cycles of read latency.
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [LAT];
    assign ram_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        for (int s = LAT - 1; s > 0; s--) rd_pipe[s] <= rd_pipe[s-1];
        rd_pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr[7:0]] : 32'h0;
        if (ram_en && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] = ram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending reads as (due cycle, port, data).
    typedef struct { int due; int port; logic [31:0] data; } pend_t;
    pend_t pend[$];
    int    cyc = 0;
    bit    m_last_i = 1'b1;
    int    m_cnt = 0;

    always @(negedge clk) begin : cmp
        int          w;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] ea, ewd, erd;
        logic [2:0]  erv;
        pend_t       p;
        cyc++;
        w = -1; ewe = 0; ebe = 0; ea = 0; ewd = 0; erv = 0; erd = 0;
        if (!rst_n) begin
            pend.delete();
            m_last_i = 1'b1;
            m_cnt = 0;
        end else if (!booted) begin
            if (bios_req) w = 0;
        end else if (d_req && i_req) begin
            w = m_last_i ? 1 : 2;
        end else if (d_req) begin
            w = 1;
        end else if (i_req) begin
            w = 2;
        end
        case (w)
            0: begin ewe = bios_we; ebe = bios_be; ea = bios_addr; ewd = bios_wdata; end
            1: begin ewe = d_we; ebe = d_be; ea = d_addr; ewd = d_wdata; end
            2: begin ewe = i_we; ebe = i_be; ea = i_addr; ewd = i_wdata; end
            default: ;
        endcase
        if (pend.size() > 0 && pend[0].due == cyc) begin
            erv[pend[0].port] = 1'b1;
            erd = pend[0].data;
            void'(pend.pop_front());
        end
        chk("bios_gnt", bios_gnt, w == 0);
        chk("d_gnt", d_gnt, w == 1);
        chk("i_gnt", i_gnt, w == 2);
        chk("ram_en", ram_en, w >= 0);
        chk("ram_we", ram_we, ewe);
        chk("ram_be", ram_be, ebe);
        chk("ram_addr", ram_addr, ea);
        chk("ram_wdata", ram_wdata, ewd);
        chk("bios_rvalid", bios_rvalid, erv[0]);
        chk("d_rvalid", d_rvalid, erv[1]);
        chk("i_rvalid", i_rvalid, erv[2]);
        if (erv[0]) chk("bios_rdata", bios_rdata, erd);
        if (erv[1]) chk("d_rdata", d_rdata, erd);
        if (erv[2]) chk("i_rdata", i_rdata, erd);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        if (w >= 0 && !ewe) begin
            p.due = cyc + LAT; p.port = w; p.data = mem[ea[7:0]];
            pend.push_back(p);
        end
        if (w == 1) m_last_i = 1'b0;
        if (w == 2) m_last_i = 1'b1;
        if (rst_n && booted && d_req && i_req && m_cnt < 65535) m_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int  k;
        int  nrv;
        bit  found;
        for (int a = 0; a < 256; a++) mem[a] = 32'h1000_0000 + a;
        for (int s = 0; s < LAT; s++) rd_pipe[s] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'h12345678;
        mem[8'h24] = 32'hAABBCCDD;
        mem[8'h30] = 32'h0BADF00D;
        mem[8'h40] = 32'hCAFEF00D;
        rst_n = 0; booted = 0;
        bios_req = 1; bios_we = 0; bios_be = 4'hF; bios_addr = 32'h10; bios_wdata = 0;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h30; d_wdata = 0;
        i_req = 0; i_we = 0; i_be = 4'hF; i_addr = 32'h40; i_wdata = 0;

        // Requests asserted during reset must not be granted.
        repeat (2) @(negedge clk);
        chk("rst_bios_gnt", bios_gnt, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_cnt", conflict_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1; bios_req = 0; d_req = 0;
        step();

        // BIOS read before boot; d_req held but locked out.
        bios_req = 1; bios_addr = 32'h10; d_req = 1;
        #1;
        chk("t1_bios_gnt", bios_gnt, 1);
        chk("t1_d_gnt", d_gnt, 0);
        step();
        bios_req = 0;
        found = 0; k = 0;
        for (int n = 1; n <= 8 && !found; n++) begin
            @(negedge clk);
            if (bios_rvalid) begin found = 1; k = n; end
        end
        chk("t1_rd_lat", k, LAT);
        chk("t1_rdata", bios_rdata, 32'hDEADBEEF);
        step();
        d_req = 0;
        step();

        // Booted conflict: d, i, d, i; BIOS ignored.
        booted = 1; bios_req = 1;
        d_req = 1; d_addr = 32'h30; i_req = 1; i_addr = 32'h40;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("t2_d_gnt", d_gnt, (n % 2) == 0);
            chk("t2_i_gnt", i_gnt, (n % 2) == 1);
            chk("t2_bios_gnt", bios_gnt, 0);
            step();
        end
        d_req = 0; i_req = 0; bios_req = 0;
        step();
        chk("t2_cnt", conflict_cnt, 4);
        repeat (4) step();

        // i read then d partial write next cycle.
        i_req = 1; i_addr = 32'h20;
        step();
        i_req = 0;
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h24; d_wdata = 32'h55667788;
        step();
        d_req = 0; d_we = 0; d_be = 4'hF;
        repeat (5) step();
        chk("t3_mem24", mem[8'h24], 32'hAABB7788);

        // BIOS read in the cycle before boot rises, then a d read.
        booted = 0; bios_req = 1; bios_addr = 32'h10;
        step();
        bios_req = 0; booted = 1; d_req = 1; d_addr = 32'h30;
        step();
        d_req = 0;
        @(negedge clk);
        chk("t4_early_bios", bios_rvalid, 0);
        @(negedge clk);
        chk("t4_bios_rvalid", bios_rvalid, 1);
        chk("t4_bios_rdata", bios_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("t4_d_rvalid", d_rvalid, 1);
        chk("t4_d_rdata", d_rdata, 32'h0BADF00D);
        step();
        repeat (2) step();

        // Reset while a read is in flight; arbitration restarts with d.
        d_req = 1; d_addr = 32'h30;
        step();
        d_req = 0;
        step();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        nrv = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            nrv += int'(bios_rvalid) + int'(d_rvalid) + int'(i_rvalid);
        end
        chk("t5_no_rvalid", nrv, 0);
        step();
        d_req = 1; i_req = 1; d_addr = 32'h30; i_addr = 32'h40;
        #1;
        chk("t5_d_first", d_gnt, 1);
        chk("t5_i_wait", i_gnt, 0);

        // Saturate the conflict counter.
        repeat (65540) step();
        d_req = 0; i_req = 0;
        step();
        chk("t6_cnt_sat", conflict_cnt, 16'hFFFF);
        repeat (LAT + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port program/data RAM between three requesters: the BIOS loader (serial boot and debug reads/writes), the CPU data port and the CPU instruction-fetch port. Access is gated by boot state: before `booted` only the BIOS may touch RAM; after it, the CPU data and instruction ports share RAM round-robin. The block issues one RAM access per cycle, tracks in-flight reads, and steers returning read data to the requester that issued them.

## Interface
Parameters:
- ADDR_WIDTH, 32, address bits on every port
- DATA_WIDTH, 32, data bits on every port; byte enables are DATA_WIDTH/8 wide
- RD_LAT, 1, fixed RAM read latency in cycles; legal range 1..4

Ports (p ∈ {bios, d, i}; every per-requester line exists once per p):
- clk  in  1  the single clock; everything is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- booted  in  1  from the BIOS; 0 means the BIOS owns RAM, 1 means the CPU owns RAM
- p_req  in  1  access request; must be held with its payload until p_gnt
- p_we  in  1  1 = write, 0 = read
- p_be  in  DATA_WIDTH/8  byte enables; writes only
- p_addr  in  ADDR_WIDTH  word address
- p_wdata  in  DATA_WIDTH  write data
- p_gnt  out  1  combinational; the access is taken this cycle
- p_rvalid  out  1  read data valid, one-cycle pulse
- p_rdata  out  DATA_WIDTH  equal to ram_rdata, qualified by p_rvalid
- ram_en  out  1  RAM access strobe
- ram_we, ram_be, ram_addr, ram_wdata  out  1 / DATA_WIDTH/8 / ADDR_WIDTH / DATA_WIDTH  payload of the granted requester
- ram_rdata  in  DATA_WIDTH  valid RD_LAT cycles after a read strobe
- conflict_cnt  out  16  count of cycles in which d_req and i_req were both asserted while booted=1; saturates at 0xFFFF

## Operation
- Eligibility:
  - booted=0: only bios is eligible. d_gnt and i_gnt stay 0 whatever their req.
  - booted=1: only d and i are eligible. bios_gnt stays 0.
- Round-robin between d and i uses a 1-bit last-granted register. Reset value: last=i, so d wins the first conflict.
  - Both requesting: grant the port that was not granted last.
  - Single requester: grant it.
  - last updates only on a d or i grant.
- At most one gnt per cycle. ram_en = OR of all gnts. With no grant, the ram_* payload outputs are don't-care but are driven to 0.
- Writes are posted: the gnt cycle completes the write, and there is no rvalid.
- Reads push {valid=1, id} into an RD_LAT-deep tag pipeline. Writes and idle cycles push valid=0. When an entry leaves the pipeline, it pulses rvalid for the port named by id.
- A booted change takes effect on the same cycle. Reads already in flight still return to their original requester, including a bios read that is in flight when booted rises.
- conflict_cnt increments once per conflict cycle and holds at 0xFFFF.

## Timing
- Grant is combinational from req, booted and last. Requesters sample gnt and advance on the same edge.
- Read: request accepted in cycle N, so p_rvalid is high in cycle N+RD_LAT. Back-to-back reads give one rvalid per cycle, in order.
- Reset: rst_n low asynchronously clears the tag pipeline, last (to i) and conflict_cnt.
  - While rst_n=0, all gnt, ram_en and rvalid outputs are 0.
  - Reads in flight at reset are dropped and never produce rvalid.
- Simultaneous events:
  - A grant and a rvalid for different ports in the same cycle are independent.
  - A new read and a returning read in the same cycle are both handled, because the pipeline shifts every cycle.
- The RAM must be read-first or write-first consistently. This block does not forward data.

## Structure
- Package ram_arb_pkg holds:
  - enum ram_port_id_t {PORT_BIOS, PORT_D, PORT_I}
  - packed struct ram_arb_tag_t {logic valid; ram_port_id_t id;}
  - the constant CONFLICT_MAX = 16'hFFFF
- Sub-module ram_arb_tag_pipe: a parameterised RD_LAT-stage shift register of ram_arb_tag_t with async active-low clear. The top level holds the grant logic, the payload mux and the counter.

## Test plan
- booted=0, bios reads 0x10 with RAM[0x10]=0xDEADBEEF → bios_gnt in the same cycle; bios_rvalid=1 and bios_rdata=0xDEADBEEF exactly RD_LAT cycles later; d_req held high throughout → d_gnt never 1.
- booted=1, d_req and i_req held together for 4 cycles → grant order d, i, d, i; conflict_cnt=4; bios_req never granted.
- booted=1, i reads 0x20 then d writes 0x24 with be=4'b0011 on the next cycle → i_rvalid only; RAM[0x24] low half updated; d_rvalid stays 0.
- RD_LAT=3, bios read issued in the cycle before booted rises → bios_rvalid still fires 3 cycles after its grant, and the d read issued one cycle later returns on d_rvalid.
- Read granted, then rst_n pulsed low before RD_LAT elapses → no rvalid on any port; after release, d wins the first d/i conflict.
- Force 65540 conflict cycles → conflict_cnt holds at 0xFFFF.
